product_accumulator: RTL and testbench

Downstream consumer of the 4-bit multiplier's 8-bit product stream. Accumulates a frame of products, delimited by a last flag or a maximum term count, into a wide sum, then presents the sum and term count on a valid/ready output port. Forms the accumulate half of a multiply-accumulate datapath used for dot-product style tests.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/acc_adder.sv | 37 +++
 rtl/product_accumulator.sv | 121 ++++++++++++
 tb/tb_product_accumulator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared widths, frame-length default and FSM state encoding
//                for the multiply-accumulate datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

  localparam int c_PROD_W    = 8;
  localparam int c_ACC_W     = 16;
  localparam int c_MAX_TERMS = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/acc_adder.sv
// ============================================================================
//  Module      : acc_adder
//  Description : Combinational ACC_W+1 bit accumulate step returning the next
//                accumulator value and the carry out. Define PRODUCT_ACC_SAT_EN
//                to clamp to all-ones on carry instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_adder
  import mac_pkg::*;
#(
  parameter int PROD_W = c_PROD_W,
  parameter int ACC_W  = c_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] w_full;

  always_comb begin
    w_full = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
    carry  = w_full[ACC_W];
`ifdef PRODUCT_ACC_SAT_EN
    // An already-clamped acc carries again on any nonzero product, so it stays clamped.
    sum    = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    sum    = w_full[ACC_W-1:0];
`endif
  end

endmodule

`default_nettype wire

// File: rtl/product_accumulator.sv
// ============================================================================
//  Module      : product_accumulator
//  Description : Accumulates a frame of unsigned products (closed by in_last or
//                MAX_TERMS beats) and presents sum/count/overflow on a
//                valid/ready port. Optional macro: PRODUCT_ACC_SAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_accumulator
  import mac_pkg::*;
#(
  parameter  int PROD_W    = c_PROD_W,
  parameter  int ACC_W     = c_ACC_W,
  parameter  int MAX_TERMS = c_MAX_TERMS,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;

  logic               w_accept;
  logic               w_first;
  logic [ACC_W-1:0]   w_base_acc;
  logic [CNT_W-1:0]   w_next_cnt;
  logic               w_next_ovf;
  logic               w_close;
  logic [ACC_W-1:0]   w_sum;
  logic               w_carry;

  // A beat in IDLE starts from zero so no stale frame state leaks in.
  always_comb begin
    w_accept   = in_valid && in_ready && !clear;
    w_first    = (r_state == S_IDLE);
    w_base_acc = w_first ? '0 : r_acc;
    w_next_cnt = (w_first ? '0 : r_count) + CNT_W'(1);
    w_next_ovf = (w_first ? 1'b0 : r_ovf) | w_carry;
    w_close    = in_last || (w_next_cnt == CNT_W'(MAX_TERMS));
  end

  acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_acc_adder (
    .acc     (w_base_acc),
    .product (in_product),
    .sum     (w_sum),
    .carry   (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= w_next_cnt;
            r_ovf   <= w_next_ovf;
            if (w_close) begin
              r_state   <= S_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= w_sum;
              out_count <= w_next_cnt;
              out_ovf   <= w_next_ovf;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
//  Module      : tb_product_accumulator
//  Description : Directed self-checking bench; a second instance with
//                ACC_W=10 shares all inputs to observe wrap/saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_product;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_sum;
  logic [4:0]  out_count;
  logic        out_ovf;

  logic        n_in_ready;
  logic        n_out_valid;
  logic [9:0]  n_out_sum;
  logic [4:0]  n_out_count;
  logic        n_out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PRODUCT_ACC_SAT_EN
  localparam logic [9:0] EXP_NARROW_SUM = 10'd1023;
`else
  localparam logic [9:0] EXP_NARROW_SUM = 10'd101;
`endif

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
  );

  product_accumulator #(.ACC_W(10)) dut_n (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (n_in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .out_valid  (n_out_valid),
    .out_ready  (out_ready),
    .out_sum    (n_out_sum),
    .out_count  (n_out_count),
    .out_ovf    (n_out_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [7:0] p, input logic l);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = l;
    tick();
    in_valid   = 1'b0;
    in_last    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d expected 0", out_valid); end
    n_checks++; if (out_sum !== 16'd0) begin n_fail++; $display("FAIL reset_sum: got %0d expected 0", out_sum); end
    n_checks++; if (out_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", out_count); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0d expected 0", out_ovf); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0d expected 1", in_ready); end
  endtask

  task automatic test_basic_frame();
    out_ready = 1'b1;
    drive_beat(8'd6, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0d expected 0", out_valid); end
    drive_beat(8'd15, 1'b0);
    drive_beat(8'd225, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0d expected 1", out_valid); end
    n_checks++; if (out_sum !== 16'd246) begin n_fail++; $display("FAIL basic_sum: got %0d expected 246", out_sum); end
    n_checks++; if (out_count !== 5'd3) begin n_fail++; $display("FAIL basic_count: got %0d expected 3", out_count); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %0d expected 0", out_ovf); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_hold_ready: got %0d expected 0", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop_valid: got %0d expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_again: got %0d expected 1", in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_beat(8'd6, 1'b0);
    drive_beat(8'd15, 1'b0);
    drive_beat(8'd225, 1'b1);
    in_valid = 1'b1; in_product = 8'd5; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'd246 || out_count !== 5'd3)
        begin n_fail++; $display("FAIL hold_stable[%0d]: got ready=%0d valid=%0d sum=%0d count=%0d expected 0/1/246/3", i, in_ready, out_valid, out_sum, out_count); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: got valid=%0d ready=%0d expected 0/1", out_valid, in_ready); end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 16'd5 || out_count !== 5'd1)
      begin n_fail++; $display("FAIL held_beat_frame: got valid=%0d sum=%0d count=%0d expected 1/5/1", out_valid, out_sum, out_count); end
    tick();
  endtask

  task automatic test_max_terms();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) drive_beat(8'd225, 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL max_valid: got %0d expected 1", out_valid); end
    n_checks++; if (out_sum !== 16'd3600) begin n_fail++; $display("FAIL max_sum: got %0d expected 3600", out_sum); end
    n_checks++; if (out_count !== 5'd16) begin n_fail++; $display("FAIL max_count: got %0d expected 16", out_count); end
    out_ready = 1'b1;
    tick();
    drive_beat(8'd225, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_count !== 5'd1 || out_sum !== 16'd225)
      begin n_fail++; $display("FAIL max_next_frame: got valid=%0d count=%0d sum=%0d expected 1/1/225", out_valid, out_count, out_sum); end
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) drive_beat(8'd1, 1'b0);
    drive_beat(8'd1, 1'b1);
    n_checks++; if (out_count !== 5'd16 || out_sum !== 16'd16) begin n_fail++; $display("FAIL max_last_single: got count=%0d sum=%0d expected 16/16", out_count, out_sum); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL max_last_no_double: got %0d expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_beat(8'd225, 1'b0);
    drive_beat(8'd225, 1'b1);
    n_checks++; if (n_out_valid !== 1'b1 || n_in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_narrow_hs: got valid=%0d ready=%0d expected 1/0", n_out_valid, n_in_ready); end
    n_checks++; if (n_out_sum !== EXP_NARROW_SUM) begin n_fail++; $display("FAIL ovf_narrow_sum: got %0d expected %0d", n_out_sum, EXP_NARROW_SUM); end
    n_checks++; if (n_out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_narrow_flag: got %0d expected 1", n_out_ovf); end
    n_checks++; if (n_out_count !== 5'd5) begin n_fail++; $display("FAIL ovf_narrow_count: got %0d expected 5", n_out_count); end
    n_checks++; if (out_sum !== 16'd1125 || out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_wide: got sum=%0d ovf=%0d expected 1125/0", out_sum, out_ovf); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    drive_beat(8'd1, 1'b0);
    drive_beat(8'd2, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_product = 8'd99; in_last = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_no_close: got %0d expected 0", out_valid); end
    drive_beat(8'd3, 1'b0);
    drive_beat(8'd4, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 16'd7 || out_count !== 5'd2)
      begin n_fail++; $display("FAIL clear_fresh_frame: got valid=%0d sum=%0d count=%0d expected 1/7/2", out_valid, out_sum, out_count); end
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL clear_hold: got valid=%0d ready=%0d expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive_beat(8'd10, 1'b0);
    drive_beat(8'd20, 1'b1);
    out_ready = 1'b1;
    tick();
    drive_beat(8'd50, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_sum !== 16'd0 || out_count !== 5'd0 || out_ovf !== 1'b0)
      begin n_fail++; $display("FAIL async_reset: got valid=%0d sum=%0d count=%0d ovf=%0d expected all 0", out_valid, out_sum, out_count, out_ovf); end
    #2 rst_n = 1'b1;
    tick();
    drive_beat(8'd9, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 16'd9 || out_count !== 5'd1)
      begin n_fail++; $display("FAIL async_after_reset: got valid=%0d sum=%0d count=%0d expected 1/9/1", out_valid, out_sum, out_count); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_max_terms();
    test_overflow();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
